speech_output_stage: RTL and testbench

//   Parametrised output stage for the Speech256 audio chain.
//   - Buffers filtered samples in a small FIFO.
//   - Applies programmable gain with saturation.
//   - Drives a 1-bit PWM (or sigma-delta) DAC.
//   - Issues one sample request per DAC period to pace the filter.

---
 rtl/speech_output_stage.sv | 217 +++++++++++++++++++++
 tb/tb_speech_output_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/speech_output_stage.sv
// -----------------------------------------------------------------------------
// speech_output_stage
//
// Output stage of the Speech256 audio chain. Filtered samples are buffered in
// a small FIFO. Once per DAC period the head sample is popped, shifted left by
// the programmable gain and saturated to IN_W bits. It is then converted to an
// offset-binary duty value that drives a 1-bit DAC. A one-cycle sample request
// at the start of every DAC period paces the upstream filter.
//
// Build option:
//   SPEECH_SDDAC_EN  when defined, the PWM comparator is replaced by a
//                    first-order sigma-delta modulator. Counter, request, FIFO,
//                    gain and load timing are identical in both builds.
//
// Ports:
//   clk         in   global Speech256 clock
//   rst         in   synchronous reset, active-high
//   sample_in   in   signed sample from the filter (IN_W)
//   sample_stb  in   write strobe, sample_in pushed when high
//   sample_rdy  out  FIFO not full
//   gain        in   left-shift amount, sampled at each DAC load (GAIN_W)
//   sample_req  out  one-cycle pulse at the start of each DAC period
//   dac_out     out  1-bit DAC output
//   overflow    out  sticky: push attempted while FIFO full
//   underrun    out  sticky: DAC load found FIFO empty
//   clr_flags   in   clears overflow and underrun
// -----------------------------------------------------------------------------
module speech_output_stage #(
   parameter int IN_W       = 16,
   parameter int DAC_W      = 8,
   parameter int GAIN_W     = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IN_W-1:0]   sample_in,
   input  logic              sample_stb,
   output logic              sample_rdy,
   input  logic [GAIN_W-1:0] gain,
   output logic              sample_req,
   output logic              dac_out,
   output logic              overflow,
   output logic              underrun,
   input  logic              clr_flags
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   // Wide enough to hold the largest shift without losing the sign.
   localparam int EXT_W = IN_W + 2**GAIN_W;
   localparam logic [DAC_W-1:0] CNT_MAX  = {DAC_W{1'b1}};
   localparam logic [DAC_W-1:0] DUTY_MID = {1'b1, {(DAC_W-1){1'b0}}};
   localparam logic [PTR_W:0]   PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};

   // Shift left by g at EXT_W bits, then clamp to the signed IN_W range.
   // The result fits when every bit from EXT_W-1 down to IN_W-1 equals the sign.
   function automatic logic [IN_W-1:0] sat_shift(input logic [IN_W-1:0]   x,
                                                 input logic [GAIN_W-1:0] g);
      logic [EXT_W-1:0]    ext;
      logic [EXT_W-1:0]    shf;
      logic [EXT_W-IN_W:0] top;
      logic [IN_W-1:0]     res;
      ext = {{(EXT_W-IN_W){x[IN_W-1]}}, x};
      shf = ext << g;
      top = shf[EXT_W-1:IN_W-1];
      if ((~|top) || (&top)) begin
         res = shf[IN_W-1:0];
      end else if (shf[EXT_W-1] == 1'b0) begin
         res = {1'b0, {(IN_W-1){1'b1}}};
      end else begin
         res = {1'b1, {(IN_W-1){1'b0}}};
      end
      return res;
   endfunction

   // Top DAC_W bits of the saturated sample, MSB inverted to offset binary.
   function automatic logic [DAC_W-1:0] to_duty(input logic [IN_W-1:0] s);
      return {~s[IN_W-1], s[IN_W-2 -: DAC_W-1]};
   endfunction

   logic [DAC_W-1:0] cnt_q, cnt_d;
   logic [DAC_W-1:0] duty_q, duty_d;
   logic [IN_W-1:0]  mem_q [FIFO_DEPTH];
   logic [IN_W-1:0]  mem_d [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
   logic             sample_req_q, sample_req_d;
   logic             sample_rdy_q, sample_rdy_d;
   logic             dac_out_q, dac_out_d;
   logic             overflow_q, overflow_d;
   logic             underrun_q, underrun_d;

   logic             load_s;
   logic             empty_s;
   logic             full_s;
   logic             full_nxt_s;
   logic             pop_s;
   logic             push_s;
   logic             ovf_set_s;
   logic             und_set_s;

`ifdef SPEECH_SDDAC_EN
   logic [DAC_W:0]   acc_q, acc_d;
`endif

   // FIFO status, load strobe and the push/pop/flag-set decisions.
   always_comb begin
      load_s  = (cnt_q == CNT_MAX);
      empty_s = (wr_ptr_q == rd_ptr_q);
      full_s  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
      pop_s     = load_s && !empty_s;
      // A pop in the same cycle frees a slot, so a push at full still fits.
      push_s    = sample_stb && (!full_s || pop_s);
      ovf_set_s = sample_stb && full_s && !pop_s;
      und_set_s = load_s && empty_s;
   end

   // Next-state logic for counter, FIFO, duty, request and sticky flags.
   always_comb begin
      cnt_d = cnt_q + {{(DAC_W-1){1'b0}}, 1'b1};
      mem_d = mem_q;
      if (push_s) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = sample_in;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         duty_d   = to_duty(sat_shift(mem_q[rd_ptr_q[PTR_W-1:0]], gain));
      end else begin
         rd_ptr_d = rd_ptr_q;
         duty_d   = duty_q;
      end
      full_nxt_s   = (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]) &&
                     (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]);
      sample_rdy_d = !full_nxt_s;
      // Counter wraps to zero on this edge exactly when load_s is high.
      sample_req_d = load_s;
      // Set events take priority over a simultaneous clear.
      if (ovf_set_s) begin
         overflow_d = 1'b1;
      end else if (clr_flags) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
      if (und_set_s) begin
         underrun_d = 1'b1;
      end else if (clr_flags) begin
         underrun_d = 1'b0;
      end else begin
         underrun_d = underrun_q;
      end
   end

`ifdef SPEECH_SDDAC_EN
   // First-order sigma-delta: the accumulator carry is the output bit.
   always_comb begin
      acc_d     = {1'b0, acc_q[DAC_W-1:0]} + {1'b0, duty_q};
      dac_out_d = acc_d[DAC_W];
   end
`else
   // PWM comparator against the period counter.
   always_comb begin
      if (cnt_q < duty_q) begin
         dac_out_d = 1'b1;
      end else begin
         dac_out_d = 1'b0;
      end
   end
`endif

   // All state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= {DAC_W{1'b0}};
         duty_q       <= DUTY_MID;
         wr_ptr_q     <= {(PTR_W+1){1'b0}};
         rd_ptr_q     <= {(PTR_W+1){1'b0}};
         sample_req_q <= 1'b0;
         sample_rdy_q <= 1'b1;
         dac_out_q    <= 1'b0;
         overflow_q   <= 1'b0;
         underrun_q   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= {IN_W{1'b0}};
         end
`ifdef SPEECH_SDDAC_EN
         acc_q        <= {(DAC_W+1){1'b0}};
`endif
      end else begin
         cnt_q        <= cnt_d;
         duty_q       <= duty_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         sample_req_q <= sample_req_d;
         sample_rdy_q <= sample_rdy_d;
         dac_out_q    <= dac_out_d;
         overflow_q   <= overflow_d;
         underrun_q   <= underrun_d;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
`ifdef SPEECH_SDDAC_EN
         acc_q        <= acc_d;
`endif
      end
   end

   assign sample_rdy = sample_rdy_q;
   assign sample_req = sample_req_q;
   assign dac_out    = dac_out_q;
   assign overflow   = overflow_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_speech_output_stage.sv
// -----------------------------------------------------------------------------
// tb_speech_output_stage
//
// Self-checking bench for speech_output_stage with default parameters.
// Each DAC period is judged by the number of high dac_out cycles in the 256
// cycles that follow a sample_req pulse. That count equals the duty loaded for
// the period, in both the PWM and the sigma-delta build. Expected duties are
// queued when a sample is pushed and popped when a period is measured.
// -----------------------------------------------------------------------------
module tb_speech_output_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sample_in;
   logic        sample_stb;
   logic        sample_rdy;
   logic [2:0]  gain;
   logic        sample_req;
   logic        dac_out;
   logic        overflow;
   logic        underrun;
   logic        clr_flags;

   int vec_cnt = 0;
   int err_cnt = 0;
   int exp_q[$];

   typedef struct {
      logic [15:0] smp;
      logic [2:0]  g;
      int          exp_duty;
   } vec_t;

   vec_t vecs[12];

   speech_output_stage dut (
      .clk        (clk),
      .rst        (rst),
      .sample_in  (sample_in),
      .sample_stb (sample_stb),
      .sample_rdy (sample_rdy),
      .gain       (gain),
      .sample_req (sample_req),
      .dac_out    (dac_out),
      .overflow   (overflow),
      .underrun   (underrun),
      .clr_flags  (clr_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp_v);
      vec_cnt++;
      if (act != exp_v) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   // Advance to the negedge of the next cycle where sample_req is high.
   task automatic wait_req();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_req && n < 300);
      if (!sample_req) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL wait_req: no sample_req within %0d cycles", n);
      end
   endtask

   task automatic push(input logic [15:0] d);
      sample_in  = d;
      sample_stb = 1'b1;
      @(negedge clk);
      sample_stb = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      @(negedge clk);
      clr_flags = 1'b0;
   endtask

   // Count dac_out highs over one period and compare with the queued duty.
   task automatic measure_check(input string name);
      int ones;
      int exp_v;
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         ones += int'(dac_out);
      end
      if (exp_q.size() == 0) begin
         vec_cnt++;
         err_cnt++;
         $display("FAIL %s: scoreboard empty, got %0d highs", name, ones);
      end else begin
         exp_v = exp_q.pop_front();
         check(name, ones, exp_v);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int req_cnt;

      vecs[0]  = '{16'h0100, 3'd3, 136};  // 0x0800
      vecs[1]  = '{16'h4000, 3'd2, 255};  // positive saturation
      vecs[2]  = '{16'h8000, 3'd2, 0};    // negative saturation
      vecs[3]  = '{16'hC000, 3'd0, 64};
      vecs[4]  = '{16'h0000, 3'd0, 128};
      vecs[5]  = '{16'hFFFF, 3'd7, 127};  // -1 << 7 = 0xFF80
      vecs[6]  = '{16'h1234, 3'd1, 164};  // 0x2468
      vecs[7]  = '{16'h7FFF, 3'd0, 255};
      vecs[8]  = '{16'hF000, 3'd3, 0};    // exactly -32768, no clamp
      vecs[9]  = '{16'h0FFF, 3'd3, 255};  // 0x7FF8, no clamp
      vecs[10] = '{16'h1000, 3'd3, 255};  // 0x8000 clamps to 0x7FFF
      vecs[11] = '{16'hFE00, 3'd4, 96};   // 0xE000

      rst        = 1'b1;
      sample_in  = 16'h0000;
      sample_stb = 1'b0;
      gain       = 3'd0;
      clr_flags  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_sample_req", int'(sample_req), 0);
      check("rst_dac_out",    int'(dac_out),    0);
      check("rst_overflow",   int'(overflow),   0);
      check("rst_underrun",   int'(underrun),   0);
      check("rst_sample_rdy", int'(sample_rdy), 1);

      // Silence after reset: midscale duty, underrun after the first load.
      exp_q.push_back(128);
      wait_req();
      check("underrun_first_load", int'(underrun), 1);
      measure_check("reset_midscale");
      pulse_clr();
      check("underrun_cleared", int'(underrun), 0);

      // Table of single-sample periods.
      for (int i = 0; i < 12; i++) begin
         gain = vecs[i].g;
         wait_req();
         push(vecs[i].smp);
         exp_q.push_back(vecs[i].exp_duty);
         wait_req();
         measure_check($sformatf("vec%0d", i));
      end

      // Fill to full, drop the fifth push, drain in order.
      gain = 3'd0;
      wait_req();
      push(16'h1000);
      push(16'h2000);
      push(16'h3000);
      push(16'h4000);
      check("full_rdy_low", int'(sample_rdy), 0);
      check("no_ovf_at_fill", int'(overflow), 0);
      push(16'h5000);
      check("ovf_set", int'(overflow), 1);
      check("ovf_rdy_low", int'(sample_rdy), 0);
      pulse_clr();
      check("ovf_cleared", int'(overflow), 0);
      exp_q.push_back(144);
      exp_q.push_back(160);
      exp_q.push_back(176);
      exp_q.push_back(192);
      exp_q.push_back(192);  // fifth sample was dropped: duty holds
      wait_req();
      measure_check("fifo_0");
      check("rdy_after_pop", int'(sample_rdy), 1);
      measure_check("fifo_1");
      measure_check("fifo_2");
      measure_check("fifo_3");
      measure_check("fifo_hold");

      // Exactly one request pulse per 256 cycles.
      req_cnt = 0;
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         req_cnt += int'(sample_req);
      end
      check("req_per_512", req_cnt, 2);

      // Push on the load cycle while full: accepted, no overflow.
      wait_req();
      push(16'hE000);
      push(16'hD000);
      push(16'hC000);
      push(16'hB000);
      repeat (251) @(negedge clk);
      push(16'hA000);
      check("pushpop_no_ovf", int'(overflow), 0);
      check("pushpop_still_full", int'(sample_rdy), 0);
      exp_q.push_back(96);
      exp_q.push_back(80);
      exp_q.push_back(64);
      exp_q.push_back(48);
      exp_q.push_back(32);
      measure_check("pp_0");
      measure_check("pp_1");
      measure_check("pp_2");
      measure_check("pp_3");
      measure_check("pp_4");

      // Reset mid-period discards FIFO contents and restores midscale.
      gain = 3'd2;
      wait_req();
      push(16'h4000);
      push(16'h8000);
      push(16'h7000);
      push(16'h1000);
      push(16'h2000);  // overflow
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_dac_out",    int'(dac_out),    0);
      check("mid_rst_sample_req", int'(sample_req), 0);
      check("mid_rst_rdy",        int'(sample_rdy), 1);
      check("mid_rst_overflow",   int'(overflow),   0);
      check("mid_rst_underrun",   int'(underrun),   0);
      exp_q.push_back(128);
      wait_req();
      check("mid_rst_fifo_empty", int'(underrun), 1);
      measure_check("mid_rst_midscale");

      check("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
